matrix_op_sequencer: RTL and testbench
======================================

Name: matrix_op_sequencer

Overview:
- Sequences one matrix operation through the shared register file and element-wise ALU.
- Accepts an instruction (src1, src2, dst, opcode) over a valid/ready handshake.
- Walks every matrix element: reads the operand registers, fires the ALU, waits for completion and writes the result to dst.
- Sits between the keypad/instruction decoder and the register file + ALU; it replaces ad-hoc read sequencing with a single owner of the datapath.

Parameters:
- ELEMS, 9, number of elements per matrix (3x3); element index width ELEM_W = $clog2(ELEMS).
- TIMEOUT, 15, maximum cycles spent in WAIT for alu_done before aborting.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- op_valid  in  1  instruction present
- op_ready  out  1  sequencer can accept (high only in IDLE)
- op_src1  in  3  first operand register
- op_src2  in  3  second operand register
- op_dst  in  3  destination register
- op_code  in  3  operation; bit 2 set = unary (no src2 read); 3'b000 = NOP
- rf_rd_en  out  1  register-file read strobe
- rf_rd_sel  out  3  register being read
- rf_elem  out  ELEM_W  element index for the current read/write
- alu_en  out  1  one-cycle ALU start pulse
- alu_op  out  3  latched opcode
- alu_done  in  1  ALU result valid
- rf_wr_en  out  1  one-cycle write strobe
- rf_wr_sel  out  3  latched dst
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error; cleared on reset or on the next accept

Behaviour:
- Reset (async, nrst low) forces state to IDLE and clears the element counter, the wait counter and all latches. All outputs go to 0 except op_ready, which is 1. Reset mid-operation abandons the op silently: no done pulse, no write.
- Outputs are Moore, decoded from the state register and latched fields only. There is no combinational input-to-output path.
- Accept: in IDLE, op_valid=1 at a rising edge latches src1, src2, dst, code and clears err and the element counter. Input changes after accept are ignored. op_valid while busy is ignored.
- States and transitions:
  - IDLE -> RD1 on accept. A NOP goes IDLE -> FIN instead.
  - RD1: rf_rd_en=1, rf_rd_sel=src1. Next is RD2, or EXEC if code[2]=1.
  - RD2: rf_rd_en=1, rf_rd_sel=src2 -> EXEC.
  - EXEC: alu_en=1 for exactly one cycle; wait counter cleared -> WAIT.
  - WAIT: alu_done is sampled only here.
    - done=1 -> WB.
    - Otherwise the wait counter increments. When it reaches TIMEOUT-1 without done: set err -> FIN.
    - alu_done on the timeout cycle: done wins, no err.
  - WB: rf_wr_en=1, rf_wr_sel=dst, rf_elem=current index.
    - index == ELEMS-1 -> FIN.
    - Otherwise increment index -> RD1.
  - FIN: done=1 for one cycle -> IDLE.
- alu_done asserted outside WAIT has no effect.
- Latency, binary op with alu_done on the first WAIT cycle:
  - 5 cycles per element (RD1, RD2, EXEC, WAIT, WB).
  - With ELEMS=9, done is high 46 cycles after the accept edge.
  - Unary ops take 4 cycles per element.
- rf_elem holds the current index in RD1/RD2/EXEC/WAIT/WB and 0 elsewhere. The index never wraps past ELEMS-1.

Optional Feature:
- Macro: SEQ_ALU_ERR_EN. It adds input alu_err (1 bit), sampled together with alu_done in WAIT.
- With the macro defined: alu_done=1 and alu_err=1 in the same cycle still gives the WB for that element. err is then set and the next state is FIN, so the remaining elements are skipped.
- Without the macro: there is no alu_err port, and err can be set only by timeout.

Decomposition:
- Shared package matrix_pkg holds:
  - the state enum state_t (IDLE, RD1, RD2, EXEC, WAIT, WB, FIN), 3 bits wide;
  - opcode constants OP_NOP=3'b000, OP_ADD=3'b001, OP_SUB=3'b010, OP_MUL=3'b011, OP_TRN=3'b100, OP_SCL=3'b101;
  - REG_W=3 and UNARY_BIT=2.
- One sub-module, seq_wait_timer, holds the WAIT counter. Its interface is clear, count enable and expired flag, and it is parameterised by TIMEOUT.

Test Plan:
- Reset: nrst low mid-WB -> all strobes 0, op_ready=1, busy=0, no done pulse; after release, a new op is accepted normally.
- ADD src1=1, src2=2, dst=3, alu_done returned 1 cycle after each alu_en:
  - 9 rd pairs (sel 1 then 2) and 9 writes to reg 3 with rf_elem 0..8;
  - done exactly 46 cycles after accept; err=0.
- TRN (unary) src1=4, dst=5 -> rf_rd_sel never equals src2, 4 cycles per element, done after 37 cycles.
- alu_done never asserted:
  - after 15 WAIT cycles err=1, done pulses and no rf_wr_en has occurred;
  - a subsequent accept clears err.
- op_valid held high through a whole op with fields changing mid-op -> only the first op runs, on the fields latched at accept; the second is accepted the cycle after FIN (op_ready=1).
- SEQ_ALU_ERR_EN defined, alu_err with done on element 2 -> writes for elements 0..2 only, err=1, done pulse.

Source files
------------

// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared types and constants for the matrix operation sequencer.
//   state_t   : sequencer FSM state encoding (3 bits)
//   OP_*      : opcode constants (bit UNARY_BIT set = unary, OP_NOP = no-op)
//   REG_W     : register-select width
//   is_unary  : helper that decodes the unary flag from an opcode
// -----------------------------------------------------------------------------
package matrix_pkg;

    localparam int REG_W     = 3;
    localparam int UNARY_BIT = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        EXEC = 3'd3,
        WAIT = 3'd4,
        WB   = 3'd5,
        FIN  = 3'd6
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_TRN = 3'b100;
    localparam logic [2:0] OP_SCL = 3'b101;

    // Unary operations read only the first operand register.
    function automatic logic is_unary(input logic [2:0] code);
        return code[UNARY_BIT];
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// -----------------------------------------------------------------------------
// seq_wait_timer
// Counts cycles spent waiting for the ALU. The count saturates at TIMEOUT-1 and
// expired is high while the count sits there.
// Ports:
//   clk     : system clock
//   nrst    : asynchronous active-low reset
//   clear   : synchronous clear of the count (has priority over cnt_en)
//   cnt_en  : advance the count by one
//   expired : count == TIMEOUT-1
// -----------------------------------------------------------------------------
module seq_wait_timer
    import matrix_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic cnt_en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_r;

    // Wait counter: cleared on request, saturating increment otherwise.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (cnt_en && (count_r != LAST_CNT)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST_CNT);

endmodule

// File: rtl/matrix_op_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_op_sequencer
// Single owner of the register-file / element-wise ALU datapath. Accepts one
// instruction over op_valid/op_ready and walks every matrix element:
// read operand(s), pulse the ALU, wait for alu_done, write the result.
//
// Optional build macro SEQ_ALU_ERR_EN adds input alu_err, sampled with
// alu_done; an ALU error still writes that element, then aborts the op with err.
//
// Ports:
//   clk, nrst                 : clock, asynchronous active-low reset
//   op_valid/op_ready         : instruction handshake (ready only in IDLE)
//   op_src1/op_src2/op_dst    : operand and destination registers
//   op_code                   : opcode (bit 2 = unary, 3'b000 = NOP)
//   rf_rd_en/rf_rd_sel        : register-file read strobe and select
//   rf_elem                   : element index for the current read/write
//   alu_en/alu_op/alu_done    : ALU start pulse, latched opcode, completion
//   rf_wr_en/rf_wr_sel        : register-file write strobe and latched dst
//   busy/done/err             : status (err is sticky until the next accept)
//
// All outputs are registered copies of the decode of the next state, so they
// line up cycle-for-cycle with the state register.
// -----------------------------------------------------------------------------
module matrix_op_sequencer
    import matrix_pkg::*;
#(
    parameter  int ELEMS   = 9,
    parameter  int TIMEOUT = 15,
    localparam int ELEM_W  = $clog2(ELEMS)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [REG_W-1:0]  op_src1,
    input  logic [REG_W-1:0]  op_src2,
    input  logic [REG_W-1:0]  op_dst,
    input  logic [2:0]        op_code,
    output logic              rf_rd_en,
    output logic [REG_W-1:0]  rf_rd_sel,
    output logic [ELEM_W-1:0] rf_elem,
    output logic              alu_en,
    output logic [2:0]        alu_op,
    input  logic              alu_done,
`ifdef SEQ_ALU_ERR_EN
    input  logic              alu_err,
`endif
    output logic              rf_wr_en,
    output logic [REG_W-1:0]  rf_wr_sel,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(ELEMS - 1);

    state_t             state_r, next_state_s;
    logic [REG_W-1:0]   src1_r, src1_nxt_s;
    logic [REG_W-1:0]   src2_r, src2_nxt_s;
    logic [REG_W-1:0]   dst_r,  dst_nxt_s;
    logic [2:0]         code_r, code_nxt_s;
    logic [ELEM_W-1:0]  elem_r, elem_nxt_s;
    logic               err_r,  err_nxt_s;
    logic               abort_s;
    logic               expired_s;

    logic               op_ready_s, rf_rd_en_s, alu_en_s, rf_wr_en_s;
    logic               busy_s, done_s;
    logic [REG_W-1:0]   rf_rd_sel_s;
    logic [ELEM_W-1:0]  rf_elem_s;

`ifdef SEQ_ALU_ERR_EN
    logic               alu_err_pend_r, alu_err_pend_nxt_s;

    // Remembers an ALU error seen with alu_done until the element's write-back.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            alu_err_pend_r <= 1'b0;
        end else begin
            alu_err_pend_r <= alu_err_pend_nxt_s;
        end
    end

    assign abort_s = alu_err_pend_r;
`else
    assign abort_s = 1'b0;
`endif

    seq_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (state_r == EXEC),
        .cnt_en  ((state_r == WAIT) && !alu_done),
        .expired (expired_s)
    );

    // State register and instruction latches.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
            src1_r  <= {REG_W{1'b0}};
            src2_r  <= {REG_W{1'b0}};
            dst_r   <= {REG_W{1'b0}};
            code_r  <= 3'b000;
            elem_r  <= {ELEM_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            src1_r  <= src1_nxt_s;
            src2_r  <= src2_nxt_s;
            dst_r   <= dst_nxt_s;
            code_r  <= code_nxt_s;
            elem_r  <= elem_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Next-state and next-latch logic.
    always_comb begin
        next_state_s = state_r;
        src1_nxt_s   = src1_r;
        src2_nxt_s   = src2_r;
        dst_nxt_s    = dst_r;
        code_nxt_s   = code_r;
        elem_nxt_s   = elem_r;
        err_nxt_s    = err_r;
`ifdef SEQ_ALU_ERR_EN
        alu_err_pend_nxt_s = alu_err_pend_r;
`endif
        case (state_r)
            IDLE: begin
                if (op_valid) begin
                    src1_nxt_s   = op_src1;
                    src2_nxt_s   = op_src2;
                    dst_nxt_s    = op_dst;
                    code_nxt_s   = op_code;
                    elem_nxt_s   = {ELEM_W{1'b0}};
                    err_nxt_s    = 1'b0;
`ifdef SEQ_ALU_ERR_EN
                    alu_err_pend_nxt_s = 1'b0;
`endif
                    next_state_s = (op_code == OP_NOP) ? FIN : RD1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD1: begin
                next_state_s = is_unary(code_r) ? EXEC : RD2;
            end
            RD2: begin
                next_state_s = EXEC;
            end
            EXEC: begin
                next_state_s = WAIT;
            end
            WAIT: begin
                // alu_done wins over a timeout landing in the same cycle.
                if (alu_done) begin
`ifdef SEQ_ALU_ERR_EN
                    alu_err_pend_nxt_s = alu_err;
`endif
                    next_state_s = WB;
                end else if (expired_s) begin
                    err_nxt_s    = 1'b1;
                    next_state_s = FIN;
                end else begin
                    next_state_s = WAIT;
                end
            end
            WB: begin
                if (abort_s) begin
                    err_nxt_s    = 1'b1;
                    next_state_s = FIN;
                end else if (elem_r == LAST_ELEM) begin
                    next_state_s = FIN;
                end else begin
                    elem_nxt_s   = elem_r + ELEM_W'(1);
                    next_state_s = RD1;
                end
            end
            FIN: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output decode from the next state and next latch values.
    always_comb begin
        op_ready_s  = 1'b0;
        busy_s      = 1'b1;
        rf_rd_en_s  = 1'b0;
        rf_rd_sel_s = {REG_W{1'b0}};
        rf_elem_s   = {ELEM_W{1'b0}};
        alu_en_s    = 1'b0;
        rf_wr_en_s  = 1'b0;
        done_s      = 1'b0;
        case (next_state_s)
            IDLE: begin
                op_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            RD1: begin
                rf_rd_en_s  = 1'b1;
                rf_rd_sel_s = src1_nxt_s;
                rf_elem_s   = elem_nxt_s;
            end
            RD2: begin
                rf_rd_en_s  = 1'b1;
                rf_rd_sel_s = src2_nxt_s;
                rf_elem_s   = elem_nxt_s;
            end
            EXEC: begin
                alu_en_s  = 1'b1;
                rf_elem_s = elem_nxt_s;
            end
            WAIT: begin
                rf_elem_s = elem_nxt_s;
            end
            WB: begin
                rf_wr_en_s = 1'b1;
                rf_elem_s  = elem_nxt_s;
            end
            FIN: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    // Output registers; op_ready is the only output that resets high.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            op_ready  <= 1'b1;
            busy      <= 1'b0;
            rf_rd_en  <= 1'b0;
            rf_rd_sel <= {REG_W{1'b0}};
            rf_elem   <= {ELEM_W{1'b0}};
            alu_en    <= 1'b0;
            alu_op    <= 3'b000;
            rf_wr_en  <= 1'b0;
            rf_wr_sel <= {REG_W{1'b0}};
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            op_ready  <= op_ready_s;
            busy      <= busy_s;
            rf_rd_en  <= rf_rd_en_s;
            rf_rd_sel <= rf_rd_sel_s;
            rf_elem   <= rf_elem_s;
            alu_en    <= alu_en_s;
            alu_op    <= code_nxt_s;
            rf_wr_en  <= rf_wr_en_s;
            rf_wr_sel <= dst_nxt_s;
            done      <= done_s;
            err       <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matrix_op_sequencer
// Directed testbench for matrix_op_sequencer. A small ALU model answers each
// alu_en with alu_done one cycle later (or never, in timeout mode). Outputs are
// sampled on the falling edge; cycle N of an op is the Nth falling edge after
// the accepting rising edge.
// -----------------------------------------------------------------------------
module tb_matrix_op_sequencer;
    import matrix_pkg::*;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [2:0] op_src1 = 3'd0;
    logic [2:0] op_src2 = 3'd0;
    logic [2:0] op_dst  = 3'd0;
    logic [2:0] op_code = 3'd0;
    logic       rf_rd_en;
    logic [2:0] rf_rd_sel;
    logic [3:0] rf_elem;
    logic       alu_en;
    logic [2:0] alu_op;
    logic       alu_done = 1'b0;
    logic       rf_wr_en;
    logic [2:0] rf_wr_sel;
    logic       busy;
    logic       done;
    logic       err;
`ifdef SEQ_ALU_ERR_EN
    logic       alu_err = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    matrix_op_sequencer dut (
        .clk       (clk),
        .nrst      (nrst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_src1   (op_src1),
        .op_src2   (op_src2),
        .op_dst    (op_dst),
        .op_code   (op_code),
        .rf_rd_en  (rf_rd_en),
        .rf_rd_sel (rf_rd_sel),
        .rf_elem   (rf_elem),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .alu_done  (alu_done),
`ifdef SEQ_ALU_ERR_EN
        .alu_err   (alu_err),
`endif
        .rf_wr_en  (rf_wr_en),
        .rf_wr_sel (rf_wr_sel),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // ALU model: 0 = answer one cycle after alu_en, 1 = never answer,
    // 2 = answer and flag alu_err for element err_elem.
    int         alu_mode = 0;
    int         err_elem = 0;
    logic       pend = 1'b0;
    logic [3:0] pend_elem = 4'd0;

    always @(negedge clk) begin
        alu_done = pend;
`ifdef SEQ_ALU_ERR_EN
        alu_err = pend && (alu_mode == 2) && (int'(pend_elem) == err_elem);
`endif
        pend      = alu_en && (alu_mode != 1);
        pend_elem = rf_elem;
    end

    // Observation record for one operation.
    logic [2:0] rd_sel_q[$];
    int         rd_elem_q[$];
    logic [2:0] wr_sel_q[$];
    int         wr_elem_q[$];
    int         done_cyc;
    int         n_en;
    logic       err_at_done;
    logic [2:0] op_at_en;

    task automatic issue(input logic [2:0] s1, input logic [2:0] s2,
                         input logic [2:0] d, input logic [2:0] c,
                         input bit hold);
        @(negedge clk);
        op_src1  = s1;
        op_src2  = s2;
        op_dst   = d;
        op_code  = c;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) op_valid = 1'b0;
    endtask

    task automatic observe(input int max_cyc);
        rd_sel_q.delete();
        rd_elem_q.delete();
        wr_sel_q.delete();
        wr_elem_q.delete();
        done_cyc    = 0;
        n_en        = 0;
        err_at_done = 1'bx;
        op_at_en    = 3'd0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk);
            if (rf_rd_en) begin
                rd_sel_q.push_back(rf_rd_sel);
                rd_elem_q.push_back(int'(rf_elem));
            end
            if (rf_wr_en) begin
                wr_sel_q.push_back(rf_wr_sel);
                wr_elem_q.push_back(int'(rf_elem));
            end
            if (alu_en) begin
                n_en++;
                op_at_en = alu_op;
            end
            if (done) begin
                done_cyc    = cyc;
                err_at_done = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int wb_cyc;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({op_ready, busy, done, err, rf_rd_en, rf_wr_en, alu_en} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 1000000",
                     {op_ready, busy, done, err, rf_rd_en, rf_wr_en, alu_en});
        end
        nrst = 1'b1;
        issue(3'd1, 3'd2, 3'd3, OP_ADD, 1'b0);
        wb_cyc = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (rf_wr_en) begin
                wb_cyc = cyc;
                break;
            end
        end
        checks++;
        if (wb_cyc !== 5) begin
            errors++;
            $display("FAIL reset_first_wb_cycle: got %0d expected 5", wb_cyc);
        end
        nrst = 1'b0;
        #1;
        checks++;
        if ({op_ready, busy, done, err, rf_rd_en, rf_wr_en, alu_en} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_mid_wb: got %b expected 1000000",
                     {op_ready, busy, done, err, rf_rd_en, rf_wr_en, alu_en});
        end
        checks++;
        if ({rf_elem, rf_wr_sel, rf_rd_sel, alu_op} !== 13'd0) begin
            errors++;
            $display("FAIL reset_latches: got %h expected 0",
                     {rf_elem, rf_wr_sel, rf_rd_sel, alu_op});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ((done !== 1'b0) || (rf_wr_en !== 1'b0) || (busy !== 1'b0)) begin
                errors++;
                $display("FAIL reset_hold_quiet: got done=%b wr=%b busy=%b expected 0 0 0",
                         done, rf_wr_en, busy);
            end
        end
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ((done !== 1'b0) || (op_ready !== 1'b1)) begin
            errors++;
            $display("FAIL reset_release_idle: got done=%b ready=%b expected 0 1", done, op_ready);
        end
    endtask

    task automatic test_add();
        int bad;
        issue(3'd1, 3'd2, 3'd3, OP_ADD, 1'b0);
        observe(60);
        checks++;
        if (done_cyc !== 46) begin
            errors++;
            $display("FAIL add_done_cycle: got %0d expected 46", done_cyc);
        end
        checks++;
        if (rd_sel_q.size() !== 18) begin
            errors++;
            $display("FAIL add_read_count: got %0d expected 18", rd_sel_q.size());
        end
        bad = 0;
        foreach (rd_sel_q[i]) begin
            if ((rd_sel_q[i] !== ((i % 2 == 0) ? 3'd1 : 3'd2)) || (rd_elem_q[i] !== i / 2)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL add_read_pattern: got %0d bad reads expected 0", bad);
        end
        checks++;
        if (wr_sel_q.size() !== 9) begin
            errors++;
            $display("FAIL add_write_count: got %0d expected 9", wr_sel_q.size());
        end
        bad = 0;
        foreach (wr_sel_q[i]) begin
            if ((wr_sel_q[i] !== 3'd3) || (wr_elem_q[i] !== i)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL add_write_pattern: got %0d bad writes expected 0", bad);
        end
        checks++;
        if ((n_en !== 9) || (op_at_en !== OP_ADD)) begin
            errors++;
            $display("FAIL add_alu_pulses: got %0d op %0d expected 9 op 1", n_en, op_at_en);
        end
        checks++;
        if (err_at_done !== 1'b0) begin
            errors++;
            $display("FAIL add_err: got %b expected 0", err_at_done);
        end
        @(negedge clk);
        checks++;
        if ((done !== 1'b0) || (op_ready !== 1'b1) || (busy !== 1'b0)) begin
            errors++;
            $display("FAIL add_back_to_idle: got done=%b ready=%b busy=%b expected 0 1 0",
                     done, op_ready, busy);
        end
    endtask

    task automatic test_unary();
        int bad;
        issue(3'd4, 3'd6, 3'd5, OP_TRN, 1'b0);
        observe(60);
        checks++;
        if (done_cyc !== 37) begin
            errors++;
            $display("FAIL trn_done_cycle: got %0d expected 37", done_cyc);
        end
        bad = 0;
        foreach (rd_sel_q[i]) begin
            if ((rd_sel_q[i] !== 3'd4) || (rd_elem_q[i] !== i)) bad++;
        end
        checks++;
        if ((rd_sel_q.size() !== 9) || (bad !== 0)) begin
            errors++;
            $display("FAIL trn_reads: got %0d reads %0d bad expected 9 reads 0 bad",
                     rd_sel_q.size(), bad);
        end
        bad = 0;
        foreach (wr_sel_q[i]) begin
            if ((wr_sel_q[i] !== 3'd5) || (wr_elem_q[i] !== i)) bad++;
        end
        checks++;
        if ((wr_sel_q.size() !== 9) || (bad !== 0)) begin
            errors++;
            $display("FAIL trn_writes: got %0d writes %0d bad expected 9 writes 0 bad",
                     wr_sel_q.size(), bad);
        end
    endtask

    task automatic test_timeout();
        alu_mode = 1;
        issue(3'd1, 3'd2, 3'd7, OP_ADD, 1'b0);
        observe(60);
        // RD1, RD2, EXEC, then 15 WAIT cycles, then FIN.
        checks++;
        if (done_cyc !== 19) begin
            errors++;
            $display("FAIL timeout_done_cycle: got %0d expected 19", done_cyc);
        end
        checks++;
        if (err_at_done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err: got %b expected 1", err_at_done);
        end
        checks++;
        if ((wr_sel_q.size() !== 0) || (n_en !== 1)) begin
            errors++;
            $display("FAIL timeout_no_write: got %0d writes %0d alu_en expected 0 writes 1 alu_en",
                     wr_sel_q.size(), n_en);
        end
        @(negedge clk);
        checks++;
        if ((err !== 1'b1) || (op_ready !== 1'b1)) begin
            errors++;
            $display("FAIL timeout_err_sticky: got err=%b ready=%b expected 1 1", err, op_ready);
        end
        alu_mode = 0;
    endtask

    task automatic test_nop_clears_err();
        issue(3'd2, 3'd3, 3'd4, OP_NOP, 1'b0);
        observe(10);
        checks++;
        if ((done_cyc !== 1) || (err_at_done !== 1'b0)) begin
            errors++;
            $display("FAIL nop_accept_clears_err: got done_cyc=%0d err=%b expected 1 0",
                     done_cyc, err_at_done);
        end
        checks++;
        if ((rd_sel_q.size() !== 0) || (wr_sel_q.size() !== 0) || (n_en !== 0)) begin
            errors++;
            $display("FAIL nop_no_traffic: got rd=%0d wr=%0d en=%0d expected 0 0 0",
                     rd_sel_q.size(), wr_sel_q.size(), n_en);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        issue(3'd1, 3'd2, 3'd3, OP_SUB, 1'b1);
        op_src1 = 3'd5;
        op_src2 = 3'd6;
        op_dst  = 3'd7;
        op_code = OP_MUL;
        observe(60);
        checks++;
        if (done_cyc !== 46) begin
            errors++;
            $display("FAIL b2b_first_done_cycle: got %0d expected 46", done_cyc);
        end
        bad = 0;
        foreach (rd_sel_q[i]) if (rd_sel_q[i] !== ((i % 2 == 0) ? 3'd1 : 3'd2)) bad++;
        foreach (wr_sel_q[i]) if (wr_sel_q[i] !== 3'd3) bad++;
        checks++;
        if ((bad !== 0) || (wr_sel_q.size() !== 9) || (op_at_en !== OP_SUB)) begin
            errors++;
            $display("FAIL b2b_first_fields: got %0d bad wr=%0d op=%0d expected 0 bad wr=9 op=2",
                     bad, wr_sel_q.size(), op_at_en);
        end
        @(negedge clk);
        checks++;
        if ((op_ready !== 1'b1) || (busy !== 1'b0)) begin
            errors++;
            $display("FAIL b2b_ready_after_fin: got ready=%b busy=%b expected 1 0", op_ready, busy);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        observe(60);
        checks++;
        if (done_cyc !== 46) begin
            errors++;
            $display("FAIL b2b_second_done_cycle: got %0d expected 46", done_cyc);
        end
        bad = 0;
        foreach (rd_sel_q[i]) if (rd_sel_q[i] !== ((i % 2 == 0) ? 3'd5 : 3'd6)) bad++;
        foreach (wr_sel_q[i]) if (wr_sel_q[i] !== 3'd7) bad++;
        checks++;
        if ((bad !== 0) || (wr_sel_q.size() !== 9) || (op_at_en !== OP_MUL)) begin
            errors++;
            $display("FAIL b2b_second_fields: got %0d bad wr=%0d op=%0d expected 0 bad wr=9 op=3",
                     bad, wr_sel_q.size(), op_at_en);
        end
    endtask

`ifdef SEQ_ALU_ERR_EN
    task automatic test_alu_err();
        int bad;
        alu_mode = 2;
        err_elem = 2;
        issue(3'd1, 3'd2, 3'd3, OP_ADD, 1'b0);
        observe(60);
        checks++;
        if ((done_cyc !== 16) || (err_at_done !== 1'b1)) begin
            errors++;
            $display("FAIL alu_err_abort: got done_cyc=%0d err=%b expected 16 1",
                     done_cyc, err_at_done);
        end
        bad = 0;
        foreach (wr_elem_q[i]) if (wr_elem_q[i] !== i) bad++;
        checks++;
        if ((wr_elem_q.size() !== 3) || (bad !== 0)) begin
            errors++;
            $display("FAIL alu_err_writes: got %0d writes %0d bad expected 3 writes 0 bad",
                     wr_elem_q.size(), bad);
        end
        alu_mode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_unary();
        test_timeout();
        test_nop_clears_err();
        test_back_to_back();
`ifdef SEQ_ALU_ERR_EN
        test_alu_err();
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
